serial_negate_scheduler: RTL and testbench
==========================================

// Module: serial_negate_scheduler
// PURPOSE
//  Shares one serial two's-complement Mealy core between two parallel requesters.
//  Arbitrates with round-robin, latches the granted word and clears the core.
//  Streams the word LSB-first into core_x and reassembles core_z into a parallel result.
//  Sits between word-level clients and the bit-serial negator.
//  Integration: the core's areset = areset | core_clr.
// PARAMETERS
//  WIDTH  8  data word width in bits, >= 2
// PORTS
//  clk         in   1      clock, rising edge
//  areset      in   1      asynchronous, active-high reset
//  req0_valid  in   1      requester 0 has a word
//  req0_data   in   WIDTH  requester 0 operand
//  req0_ready  out  1      requester 0 word accepted this cycle when valid&ready
//  req1_valid  in   1      requester 1 has a word
//  req1_data   in   WIDTH  requester 1 operand
//  req1_ready  out  1      requester 1 word accepted this cycle when valid&ready
//  core_clr    out  1      registered one-cycle clear pulse to the serial core
//  core_x      out  1      registered serial operand bit to the core, LSB first
//  core_z      in   1      serial result bit from the core (Mealy, same cycle as core_x)
//  res_valid   out  1      result available
//  res_data    out  WIDTH  (-operand) mod 2^WIDTH
//  res_id      out  1      requester index that owns res_data
//  res_ready   in   1      consumer takes result when res_valid&res_ready
// BEHAVIOUR
//  - Reset: state=IDLE, core_clr=0, core_x=0, res_valid=0, res_data=0, res_id=0, last_grant=1.
//    With last_grant=1, req0 wins the first contention.
//  - FSM states: IDLE, CLEAR, SHIFT, DONE.
//  - IDLE:
//    - grant = only valid requester; if both valid, the one != last_grant.
//    - reqN_ready = (state==IDLE) & grant==N, combinational; never both high.
//    - On accept: shreg <= data, res_id <= N, last_grant <= N, core_clr <= 1, go to CLEAR.
//  - CLEAR (1 cycle):
//    - core_clr high; core state forced to 0.
//    - core_x <= shreg[0], cnt <= 0, core_clr <= 0, go to SHIFT.
//  - SHIFT (exactly WIDTH cycles):
//    - Each cycle: capture core_z into the result register MSB, shifting right.
//    - shreg shifts right; core_x <= next bit; cnt++.
//    - After cnt==WIDTH-1: res_valid <= 1, core_x <= 0, go to DONE.
//  - DONE: res_valid, res_data and res_id held stable until res_ready=1.
//    On handshake: res_valid <= 0, go to IDLE.
//  - Latency: accept at cycle T -> res_valid high at T+WIDTH+2.
//    Minimum issue interval is WIDTH+3 cycles; no IDLE bypass.
//  - core_x=0 and core_clr=0 in every state other than those above.
//  - Arithmetic: result is the two's complement modulo 2^WIDTH, no overflow flag.
//    0 -> 0, and 2^(WIDTH-1) -> 2^(WIDTH-1).
//  - Requesters must hold valid/data until ready. Deasserting valid before accept is legal and ignored.
//  - res_ready already high on entry to DONE: res_valid is high for exactly 1 cycle.
//  - areset mid-operation (any state): immediate return to the reset values.
//    The partial result is discarded and no ready/valid is issued for the aborted word.
// TESTING
//  - WIDTH=8: req0 valid with 0x01 -> req0_ready in IDLE, core_clr for 1 cycle; res_data=0xFF, res_id=0, res_valid at T+10.
//  - Single words 0x00, 0x80, 0xFF, 0x06 -> res_data 0x00, 0x80, 0x01, 0xFA.
//  - Both valid from reset, req0=0x05, req1=0x03, both held -> 0xFB/id0, then 0xFD/id1, then strictly alternating.
//  - res_ready low 5 cycles in DONE -> res_valid/res_data/res_id stable; req*_ready stays 0; completes on res_ready=1.
//  - areset pulse on the 4th SHIFT cycle -> all outputs 0; then req1 with 0x06 -> 0xFA/id1 (core was cleared).
//  - Back-to-back words with res_ready tied high -> accepts exactly WIDTH+3 cycles apart; core_x=0 outside SHIFT.

Source files
------------

// File: rtl/serial_negate_scheduler.sv
// -----------------------------------------------------------------------------
// serial_negate_scheduler
//
// Shares one bit-serial two's-complement negator between two word-level
// requesters. A round-robin arbiter picks a requester in IDLE and latches its
// word. The core is then cleared for one cycle. The word is streamed LSB-first
// into the core, and the core's Mealy output is reassembled into a parallel
// result that is held until the consumer takes it.
//
// The serial core is reset by (areset | core_clr) at the integration level.
//
// Ports
//   clk, areset            clock (rising edge), async active-high reset
//   req0_valid/data/ready  requester 0 word handshake (ready is combinational)
//   req1_valid/data/ready  requester 1 word handshake (ready is combinational)
//   core_clr               registered one-cycle clear pulse to the serial core
//   core_x                 registered serial operand bit, LSB first
//   core_z                 serial result bit from the core, same cycle as core_x
//   res_valid/data/id      result handshake: (-operand) mod 2^WIDTH and owner
//   res_ready              consumer accepts the result when valid & ready
// -----------------------------------------------------------------------------
module serial_negate_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             core_clr,
  output logic             core_x,
  input  logic             core_z,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             core_clr_q, core_clr_d;
  logic             core_x_q, core_x_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic             last_grant_q, last_grant_d;

  logic             grant_valid;
  logic             grant_id;

  // Round-robin choice: a lone requester wins; on contention the one that
  // was not granted last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end else begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && grant_valid && !grant_id;
  assign req1_ready = (state_q == ST_IDLE) && grant_valid && grant_id;

  // Next-state and datapath: everything holds unless a state says otherwise;
  // core_clr and core_x fall back to 0 outside the states that drive them.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    res_data_d   = res_data_q;
    cnt_d        = cnt_q;
    core_clr_d   = 1'b0;
    core_x_d     = 1'b0;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          shreg_d      = grant_id ? req1_data : req0_data;
          res_id_d     = grant_id;
          last_grant_d = grant_id;
          core_clr_d   = 1'b1;
          state_d      = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // The core sits in reset this cycle, so bit 0 lands on a clean state.
        core_x_d = shreg_q[0];
        shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d    = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Result bits enter at the MSB so the first (LSB) bit ends at bit 0.
        res_data_d = {core_z, res_data_q[WIDTH-1:1]};
        cnt_d      = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_valid_d = 1'b1;
          core_x_d    = 1'b0;
          state_d     = ST_DONE;
        end else begin
          core_x_d = shreg_q[0];
          shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
          state_d  = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; areset aborts any word in flight.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      res_data_q   <= '0;
      cnt_q        <= '0;
      core_clr_q   <= 1'b0;
      core_x_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      res_data_q   <= res_data_d;
      cnt_q        <= cnt_d;
      core_clr_q   <= core_clr_d;
      core_x_q     <= core_x_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign core_clr  = core_clr_q;
  assign core_x    = core_x_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_serial_negate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_negate_scheduler
//
// Bench for serial_negate_scheduler (WIDTH=8) with a behavioural bit-serial
// negator attached. A per-cycle model tracks the expected phase (clear, shift
// bits, done), the expected grants and the scoreboard of pending results.
// -----------------------------------------------------------------------------
module tb_serial_negate_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         areset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         core_clr, core_x, core_z;
  logic         res_valid, res_id, res_ready;
  logic [W-1:0] res_data;

  always #5 clk = ~clk;

  serial_negate_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .areset     (areset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .core_clr   (core_clr),
    .core_x     (core_x),
    .core_z     (core_z),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  // Serial negator: copy bits up to and including the first 1, invert after.
  logic core_rst;
  logic core_s;
  assign core_rst = areset | core_clr;
  assign core_z   = core_x ^ core_s;

  always @(posedge clk or posedge core_rst) begin
    if (core_rst) core_s <= 1'b0;
    else          core_s <= core_s | core_x;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  exp_t         sb[$];
  int           checks, errors;
  int           ph;
  logic         in_done, m_last, m_acc, m_acc_id;
  logic [W-1:0] word;
  int           s_cyc, last_acc, gap;
  logic         s_res_valid, s_res_id;
  logic [W-1:0] s_res_data;
  vec_t         vec [6];
  logic [W-1:0] b2b [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample and check at the falling edge, advance the model, then
  // return just after the next rising edge where inputs may be changed.
  task automatic step();
    logic idle, e0, e1, ex;
    exp_t ent;
    @(negedge clk);
    s_cyc       = cyc;
    m_acc       = 1'b0;
    s_res_valid = res_valid;
    s_res_data  = res_data;
    s_res_id    = res_id;
    if (areset) begin
      chk("rst_core_clr",  32'(core_clr),   32'd0);
      chk("rst_core_x",    32'(core_x),     32'd0);
      chk("rst_res_valid", 32'(res_valid),  32'd0);
      chk("rst_res_data",  32'(res_data),   32'd0);
      chk("rst_res_id",    32'(res_id),     32'd0);
      chk("rst_req0_rdy",  32'(req0_ready), 32'd0);
      chk("rst_req1_rdy",  32'(req1_ready), 32'd0);
      ph      = 0;
      in_done = 1'b0;
      m_last  = 1'b1;
      sb.delete();
    end else begin
      idle = (ph == 0) && !in_done;
      e0   = idle && req0_valid && (!req1_valid || m_last);
      e1   = idle && req1_valid && (!req0_valid || !m_last);
      ex   = (ph >= 2) ? word[ph-2] : 1'b0;
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("core_clr",   32'(core_clr),   32'(ph == 1));
      chk("core_x",     32'(core_x),     32'(ex));
      chk("res_valid",  32'(res_valid),  32'(in_done));
      if (in_done) begin
        if (sb.size() == 0) begin
          chk("sb_pending", 32'(sb.size()), 32'd1);
        end else begin
          chk("sb_res_data", 32'(res_data), 32'(sb[0].data));
          chk("sb_res_id",   32'(res_id),   32'(sb[0].id));
          if (res_ready) void'(sb.pop_front());
        end
        if (res_ready) in_done = 1'b0;
      end
      if (ph == W + 1) begin
        ph      = 0;
        in_done = 1'b1;
      end else if (ph > 0) begin
        ph++;
      end else if (e0 || e1) begin
        ph       = 1;
        m_acc    = 1'b1;
        m_acc_id = e1;
        m_last   = e1;
        word     = e1 ? req1_data : req0_data;
        ent.id   = e1;
        ent.data = ~word + 8'd1;
        sb.push_back(ent);
        gap      = s_cyc - last_acc;
        last_acc = s_cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || ph != 0 || in_done) && g < 100) begin
      step();
      g++;
    end
    chk("drain_done", 32'(g < 100), 32'd1);
  endtask

  task automatic send(input logic id, input logic [W-1:0] d, input logic [W-1:0] e);
    int g, t0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    g = 0;
    do begin step(); g++; end while (!m_acc && g < 50);
    chk("accept",    32'(m_acc),    32'd1);
    chk("accept_id", 32'(m_acc_id), 32'(id));
    t0 = s_cyc;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    g = 0;
    do begin step(); g++; end while (!s_res_valid && g < 50);
    chk("latency",  32'(s_cyc - t0), 32'(W + 2));
    chk("tbl_data", 32'(s_res_data), 32'(e));
    chk("tbl_id",   32'(s_res_id),   32'(id));
    drain();
  endtask

  initial begin
    int n, g;
    vec[0] = '{1'b0, 8'h01, 8'hFF};
    vec[1] = '{1'b0, 8'h00, 8'h00};
    vec[2] = '{1'b0, 8'h80, 8'h80};
    vec[3] = '{1'b1, 8'hFF, 8'h01};
    vec[4] = '{1'b0, 8'h06, 8'hFA};
    vec[5] = '{1'b1, 8'h7F, 8'h81};
    b2b[0] = 8'h12; b2b[1] = 8'h34; b2b[2] = 8'h80; b2b[3] = 8'hFE;

    checks = 0; errors = 0; ph = 0; in_done = 1'b0; m_last = 1'b1;
    m_acc = 1'b0; m_acc_id = 1'b0; word = '0; last_acc = 0; gap = 0;
    areset = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    step();
    step();
    areset = 1'b0;

    // Contention from reset: req0 first, then strict alternation.
    req0_data = 8'h05; req1_data = 8'h03;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0; g = 0;
    while (n < 4 && g < 200) begin
      step();
      g++;
      if (m_acc) begin
        chk("rr_id", 32'(m_acc_id), 32'(n % 2));
        if (n > 0) chk("rr_gap", 32'(gap), 32'(W + 3));
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Single words with table expectations.
    for (int i = 0; i < 6; i++) send(vec[i].id, vec[i].data, vec[i].exp);

    // Consumer stalls in DONE while both requesters wait.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h3C;
    g = 0;
    do begin step(); g++; end while (!m_acc && g < 50);
    req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    g = 0;
    do begin step(); g++; end while (!s_res_valid && g < 50);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(s_res_valid), 32'd1);
      chk("stall_data",  32'(s_res_data),  32'h0000_00C4);
      chk("stall_id",    32'(s_res_id),    32'd0);
      if (i < 4) step();
    end
    res_ready = 1'b1;
    n = 0; g = 0;
    while (n < 2 && g < 100) begin
      step();
      g++;
      if (m_acc) begin
        chk("stall_next_id", 32'(m_acc_id), 32'(n == 0));
        if (m_acc_id) req1_valid = 1'b0;
        else          req0_valid = 1'b0;
        n++;
      end
    end
    chk("stall_accepts", 32'(n), 32'd2);
    drain();

    // Reset in the 4th shift cycle aborts the word; the core starts clean.
    req0_valid = 1'b1; req0_data = 8'h55;
    g = 0;
    do begin step(); g++; end while (!m_acc && g < 50);
    req0_valid = 1'b0;
    g = 0;
    while (ph != 5 && g < 20) begin step(); g++; end
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    chk("abort_no_valid", 32'(s_res_valid), 32'd0);
    send(1'b1, 8'h06, 8'hFA);

    // Back-to-back words with the consumer always ready.
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = b2b[0];
    n = 0; g = 0;
    while (n < 4 && g < 200) begin
      step();
      g++;
      if (m_acc) begin
        if (n > 0) chk("b2b_gap", 32'(gap), 32'(W + 3));
        n++;
        if (n < 4) req0_data = b2b[n];
        else       req0_valid = 1'b0;
      end
    end
    chk("b2b_count", 32'(n), 32'd4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
